// File: rtl/alu_issue_wb_if.sv
// Bundle of the instruction, ALU, writeback and debug signals of the issue/writeback stage.
// The slave side is the stage itself; the master side is the instruction producer plus the ALU.
interface alu_issue_wb_if;
    logic        ins_valid;
    logic        ins_ready;
    logic [15:0] ins_data;
    logic        alu_en;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_func;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        err_timeout;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    modport slave (
        input  ins_valid, ins_data, alu_done, alu_result, dbg_addr,
        output ins_ready, alu_en, alu_a, alu_b, alu_func,
               wb_valid, wb_addr, wb_data, err_timeout, dbg_data
    );

    modport master (
        output ins_valid, ins_data, alu_done, alu_result, dbg_addr,
        input  ins_ready, alu_en, alu_a, alu_b, alu_func,
               wb_valid, wb_addr, wb_data, err_timeout, dbg_data
    );
endinterface

// File: rtl/alu_issue_wb.sv
// Serial issue/writeback stage around a 16-bit ALU with an 8x16 register file:
// accept, issue a one-cycle enable, then wait (bounded) for the result and write it back.
module alu_issue_wb #(
    parameter int TIMEOUT = 4,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    alu_issue_wb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state;
    logic [7:0][15:0]  rf;
    logic [2:0]        rd_q;
    logic [CW-1:0]     cnt;

    logic [2:0]  f_func, f_rd, f_ra, f_rb;
    logic        f_use_imm;
    logic [15:0] imm16, ra_val, rb_val;
    logic        drop_wr;

    assign f_func    = bus.ins_data[15:13];
    assign f_rd      = bus.ins_data[12:10];
    assign f_ra      = bus.ins_data[9:7];
    assign f_rb      = bus.ins_data[6:4];
    assign f_use_imm = bus.ins_data[3];
    // In immediate mode the rb field doubles as the upper three immediate bits.
    assign imm16     = {10'b0, bus.ins_data[6:4], bus.ins_data[2:0]};

    assign ra_val       = (R0_ZERO && f_ra == 3'd0) ? 16'd0 : rf[f_ra];
    assign rb_val       = (R0_ZERO && f_rb == 3'd0) ? 16'd0 : rf[f_rb];
    assign bus.dbg_data = (R0_ZERO && bus.dbg_addr == 3'd0) ? 16'd0 : rf[bus.dbg_addr];
    assign bus.ins_ready = (state == IDLE);
    assign drop_wr      = R0_ZERO && (rd_q == 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rf              <= '0;
            rd_q            <= '0;
            cnt             <= '0;
            bus.alu_en      <= 1'b0;
            bus.alu_a       <= '0;
            bus.alu_b       <= '0;
            bus.alu_func    <= '0;
            bus.wb_valid    <= 1'b0;
            bus.wb_addr     <= '0;
            bus.wb_data     <= '0;
            bus.err_timeout <= 1'b0;
        end else begin
            bus.wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ins_valid) begin
                        rd_q         <= f_rd;
                        state        <= ISSUE;
                        bus.alu_en   <= 1'b1;
                        bus.alu_func <= f_func;
                        bus.alu_a    <= ra_val;
                        bus.alu_b    <= f_use_imm ? imm16 : rb_val;
                    end
                end
                ISSUE: begin
                    bus.alu_en <= 1'b0;
                    state      <= WB;
                    cnt        <= '0;
                end
                WB: begin
                    if (bus.alu_done) begin
                        if (!drop_wr)
                            rf[rd_q] <= bus.alu_result;
                        // Pulse even for a dropped r0 write so the producer sees completion.
                        bus.wb_valid <= 1'b1;
                        bus.wb_addr  <= rd_q;
                        bus.wb_data  <= bus.alu_result;
                        state        <= IDLE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        bus.err_timeout <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb: a registered one-cycle ALU model answers each enable pulse,
// and every expected value below is a hand-computed constant.
module tb_alu_issue_wb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   hang = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_issue_wb_if bus();

    alu_issue_wb #(.TIMEOUT(4), .R0_ZERO(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [15:0] alu_f(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
        case (f)
            3'd0:    alu_f = a | b;
            3'd1:    alu_f = a + b;
            3'd2:    alu_f = a - b;
            3'd3:    alu_f = a & b;
            3'd4:    alu_f = a ^ b;
            default: alu_f = a;
        endcase
    endfunction

    // One-cycle ALU: result and done appear the cycle after it samples alu_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.alu_done   <= 1'b0;
            bus.alu_result <= '0;
        end else begin
            bus.alu_done <= bus.alu_en & ~hang;
            if (bus.alu_en)
                bus.alu_result <= alu_f(bus.alu_func, bus.alu_a, bus.alu_b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dbg(input logic [2:0] a, input logic [15:0] exp);
        bus.dbg_addr = a;
        #1;
        chk($sformatf("dbg_r%0d", a), 32'(bus.dbg_data), 32'(exp));
    endtask

    // Called at a negedge with the stage idle; returns at a negedge with the stage idle.
    task automatic run_ins(input logic [15:0] d, input logic [15:0] ea, input logic [15:0] eb,
                           input logic [2:0] ef, input logic [2:0] eaddr, input logic [15:0] edata);
        bus.ins_valid = 1'b1;
        bus.ins_data  = d;
        @(negedge clk);
        bus.ins_valid = 1'b0;
        chk("issue_en",    32'(bus.alu_en),    32'd1);
        chk("issue_ready", 32'(bus.ins_ready), 32'd0);
        chk("alu_a",       32'(bus.alu_a),     32'(ea));
        chk("alu_b",       32'(bus.alu_b),     32'(eb));
        chk("alu_func",    32'(bus.alu_func),  32'(ef));
        @(negedge clk);
        chk("wb_en_low",   32'(bus.alu_en),    32'd0);
        chk("wb_early",    32'(bus.wb_valid),  32'd0);
        @(negedge clk);
        chk("wb_valid",    32'(bus.wb_valid),  32'd1);
        chk("wb_addr",     32'(bus.wb_addr),   32'(eaddr));
        chk("wb_data",     32'(bus.wb_data),   32'(edata));
        chk("wb_ready",    32'(bus.ins_ready), 32'd1);
        @(negedge clk);
        chk("wb_pulse1",   32'(bus.wb_valid),  32'd0);
    endtask

    initial begin
        logic [15:0] stream [3];
        logic [9:0]  rv, ev, wv;
        int          idx;

        bus.ins_valid = 1'b0;
        bus.ins_data  = '0;
        bus.dbg_addr  = '0;

        // Reset state
        #12;
        chk("rst_alu_en",  32'(bus.alu_en),      32'd0);
        chk("rst_wb",      32'(bus.wb_valid),    32'd0);
        chk("rst_err",     32'(bus.err_timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready",   32'(bus.ins_ready),   32'd1);

        // r1 = 0 | 5
        run_ins(16'h040D, 16'd0, 16'd5, 3'd0, 3'd1, 16'd5);
        chk_dbg(3'd1, 16'd5);
        // r2 = r1 + r1
        run_ins(16'h2890, 16'd5, 16'd5, 3'd1, 3'd2, 16'd10);
        chk_dbg(3'd2, 16'd10);
        // r0 = r1 + r2, dropped
        run_ins(16'h20A0, 16'd5, 16'd10, 3'd1, 3'd0, 16'd15);
        chk_dbg(3'd0, 16'd0);

        // Back-to-back with ins_valid held: r3=r1+r2=15, r4=r3-r1=10, r5=r4^7=13
        stream[0] = 16'h2CA0;
        stream[1] = 16'h5190;
        stream[2] = 16'h960F;
        idx = 0;
        rv = '0; ev = '0; wv = '0;
        for (int i = 0; i < 10; i++) begin
            rv[i] = bus.ins_ready;
            ev[i] = bus.alu_en;
            wv[i] = bus.wb_valid;
            if (bus.ins_ready) begin
                if (idx < 3) begin
                    bus.ins_valid = 1'b1;
                    bus.ins_data  = stream[idx];
                    idx++;
                end else begin
                    bus.ins_valid = 1'b0;
                end
            end
            if (i < 9) @(negedge clk);
        end
        chk("stream_ready", 32'(rv), 32'h249);
        chk("stream_en",    32'(ev), 32'h092);
        chk("stream_wb",    32'(wv), 32'h248);
        chk_dbg(3'd3, 16'd15);
        chk_dbg(3'd4, 16'd10);
        chk_dbg(3'd5, 16'd13);

        // Reset while in WB: everything returns to zero
        @(negedge clk);
        bus.ins_valid = 1'b1;
        bus.ins_data  = 16'h2CA0;
        @(negedge clk);
        bus.ins_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_alu_en",   32'(bus.alu_en),      32'd0);
        chk("mrst_alu_a",    32'(bus.alu_a),       32'd0);
        chk("mrst_alu_b",    32'(bus.alu_b),       32'd0);
        chk("mrst_alu_func", 32'(bus.alu_func),    32'd0);
        chk("mrst_wb_valid", 32'(bus.wb_valid),    32'd0);
        chk("mrst_wb_addr",  32'(bus.wb_addr),     32'd0);
        chk("mrst_wb_data",  32'(bus.wb_data),     32'd0);
        chk("mrst_err",      32'(bus.err_timeout), 32'd0);
        for (int a = 0; a < 8; a++) chk_dbg(3'(a), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_ready",    32'(bus.ins_ready),   32'd1);

        // r6 = 0 | 3, then a hung ALU must not disturb r6
        run_ins(16'h180B, 16'd0, 16'd3, 3'd0, 3'd6, 16'd3);
        hang = 1'b1;
        bus.ins_valid = 1'b1;
        bus.ins_data  = 16'h180F;
        @(negedge clk);
        bus.ins_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("to_err_early",  32'(bus.err_timeout), 32'd0);
        chk("to_busy",       32'(bus.ins_ready),   32'd0);
        @(negedge clk);
        chk("to_err",        32'(bus.err_timeout), 32'd1);
        chk("to_ready",      32'(bus.ins_ready),   32'd1);
        chk("to_no_wb",      32'(bus.wb_valid),    32'd0);
        chk_dbg(3'd6, 16'd3);
        bus.ins_valid = 1'b1;
        @(negedge clk);
        bus.ins_valid = 1'b0;
        chk("to_sticky",     32'(bus.err_timeout), 32'd1);
        chk("to_issue_en",   32'(bus.alu_en),      32'd1);
        rst = 1'b1;
        #1;
        chk("irst_alu_en",   32'(bus.alu_en),      32'd0);
        chk("irst_err",      32'(bus.err_timeout), 32'd0);
        chk("irst_ready",    32'(bus.ins_ready),   32'd1);
        @(negedge clk);
        rst  = 1'b0;
        hang = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
